// File: rtl/copro_mem_pkg.sv
// Shared types and address map for the 32016 co-processor memory arbiter.
// CONFIG_REG_EN adds the config-switch window at CFG_BASE.
package copro_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_ACC,
    ST_ROM_ACC,
    ST_TUBE_ACC,
    ST_NULL_ACC,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_ROM,
    RGN_TUBE,
    RGN_NULL
  } region_e;

  localparam logic [23:0] RAM_TOP   = 24'h1F_FFFF;
  localparam logic [23:0] ROM_BASE  = 24'hF0_0000;
  localparam logic [23:0] ROM_MASK  = 24'hFC_0000;
  localparam logic [23:0] TUBE_BASE = 24'hFF_FFF0;
  localparam logic [23:0] TUBE_MASK = 24'hFF_FFF0;
  localparam logic [23:0] CFG_BASE  = 24'hF9_0000;
  localparam logic [23:0] CFG_MASK  = 24'hFF_FFF0;

  localparam int unsigned CNT_W = 8;

  function automatic logic in_range(input logic [23:0] addr,
                                    input logic [23:0] base,
                                    input logic [23:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/copro_addr_decode.sv
// Combinational CPU address decode onto RAM / ROM / tube / unmapped regions.
// CONFIG_REG_EN enables the read-only config-switch window.
module copro_addr_decode
  import copro_mem_pkg::*;
(
  input  logic [23:0] addr,
  input  logic        bootmode,
  input  logic        rd,
  output region_e     region,
  output logic        cfg_hit
);

  always_comb begin
    region  = RGN_NULL;
    cfg_hit = 1'b0;
    if (bootmode) begin
      // Boot mode sends every read to ROM; writes fall through to unmapped.
      if (rd) region = RGN_ROM;
    end else if (addr <= RAM_TOP) begin
      region = RGN_RAM;
    end else if (in_range(addr, ROM_BASE, ROM_MASK)) begin
      region = RGN_ROM;
    end else if (in_range(addr, TUBE_BASE, TUBE_MASK)) begin
      region = RGN_TUBE;
`ifdef CONFIG_REG_EN
    end else if (rd && in_range(addr, CFG_BASE, CFG_MASK)) begin
      cfg_hit = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/copro_mem_arbiter.sv
// CPU / DMA arbiter and wait-state sequencer for SRAM, boot ROM and tube.
// CONFIG_REG_EN returns cfg_sw on reads of the config window.
module copro_mem_arbiter
  import copro_mem_pkg::*;
#(
  parameter int unsigned RAM_WAIT  = 2,
  parameter int unsigned ROM_WAIT  = 1,
  parameter int unsigned TUBE_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [23:0] cpu_a,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_di,
  output logic [31:0] cpu_q,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [18:0] dma_a,
  input  logic [31:0] dma_di,
  output logic [31:0] dma_q,
  output logic        dma_ack,
  output logic        ram_cs_b,
  output logic        ram_oe_b,
  output logic        ram_we_b,
  output logic [3:0]  ram_be_b,
  output logic [18:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_wdata_oe,
  input  logic [31:0] ram_rdata,
  output logic [12:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        tube_cs_b,
  output logic [2:0]  tube_addr,
  output logic        tube_rnw,
  output logic [7:0]  tube_wdata,
  input  logic [7:0]  tube_rdata,
  input  logic [7:0]  cfg_sw,
  output logic        bootmode
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             own_dma_q, own_dma_d;
  logic             boot_hit_q, boot_hit_d;
  logic             cfg_q, cfg_d;
  logic             fair_q, fair_d;
  logic             bootmode_q, bootmode_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      cpu_rdata_q, cpu_rdata_d;
  logic [31:0]      dma_rdata_q, dma_rdata_d;
  logic [18:0]      ram_addr_q, ram_addr_d;
  logic [12:0]      rom_addr_q, rom_addr_d;
  logic [2:0]       tube_addr_q, tube_addr_d;
  logic [7:0]       tube_wdata_q, tube_wdata_d;

  region_e     cpu_region;
  logic        cpu_cfg_hit;
  logic        cpu_req;
  logic        grant_dma;
  logic        grant_cpu;
  logic [31:0] acc_rdata;
  logic [31:0] null_rdata;

  copro_addr_decode u_decode (
    .addr     (cpu_a),
    .bootmode (bootmode_q),
    .rd       (cpu_rd),
    .region   (cpu_region),
    .cfg_hit  (cpu_cfg_hit)
  );

`ifdef CONFIG_REG_EN
  assign null_rdata = cfg_q ? {24'b0, cfg_sw} : '0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_sw, cfg_q};
  assign null_rdata = '0;
`endif

  assign cpu_req   = cpu_rd | cpu_wr;
  assign grant_dma = (state_q == ST_IDLE) && dma_req && (fair_q || !cpu_req);
  assign grant_cpu = (state_q == ST_IDLE) && cpu_req && !grant_dma;

  always_comb begin
    case (state_q)
      ST_RAM_ACC:  acc_rdata = ram_rdata;
      ST_ROM_ACC:  acc_rdata = rom_data;
      ST_TUBE_ACC: acc_rdata = {4{tube_rdata}};
      default:     acc_rdata = null_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    own_dma_d    = own_dma_q;
    boot_hit_d   = boot_hit_q;
    cfg_d        = cfg_q;
    fair_d       = fair_q;
    bootmode_d   = bootmode_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    ram_addr_d   = ram_addr_q;
    rom_addr_d   = rom_addr_q;
    tube_addr_d  = tube_addr_q;
    tube_wdata_d = tube_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_dma) begin
          state_d    = ST_RAM_ACC;
          cnt_d      = CNT_W'(RAM_WAIT - 1);
          own_dma_d  = 1'b1;
          wr_d       = dma_wr;
          wdata_d    = dma_di;
          be_d       = '1;
          ram_addr_d = dma_a;
          fair_d     = 1'b0;
        end else if (grant_cpu) begin
          own_dma_d    = 1'b0;
          wr_d         = ~cpu_rd;
          wdata_d      = cpu_di;
          be_d         = cpu_be;
          tube_addr_d  = cpu_a[3:1];
          tube_wdata_d = cpu_a[1] ? cpu_di[23:16] : cpu_di[7:0];
          boot_hit_d   = in_range(cpu_a, ROM_BASE, ROM_MASK);
          cfg_d        = cpu_cfg_hit;
          fair_d       = dma_req;
          case (cpu_region)
            RGN_RAM: begin
              state_d    = ST_RAM_ACC;
              cnt_d      = CNT_W'(RAM_WAIT - 1);
              ram_addr_d = cpu_a[20:2];
            end
            RGN_ROM: begin
              state_d    = ST_ROM_ACC;
              cnt_d      = CNT_W'(ROM_WAIT - 1);
              rom_addr_d = cpu_a[14:2];
            end
            RGN_TUBE: begin
              state_d = ST_TUBE_ACC;
              cnt_d   = CNT_W'(TUBE_WAIT - 1);
            end
            default: begin
              state_d = ST_NULL_ACC;
              cnt_d   = '0;
            end
          endcase
        end
      end

      ST_RAM_ACC, ST_ROM_ACC, ST_TUBE_ACC, ST_NULL_ACC: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            if (own_dma_q) dma_rdata_d = acc_rdata;
            else           cpu_rdata_d = acc_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!own_dma_q && !wr_q && boot_hit_q) bootmode_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      own_dma_q    <= 1'b0;
      boot_hit_q   <= 1'b0;
      cfg_q        <= 1'b0;
      fair_q       <= 1'b0;
      bootmode_q   <= 1'b1;
      be_q         <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      ram_addr_q   <= '0;
      rom_addr_q   <= '0;
      tube_addr_q  <= '0;
      tube_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      own_dma_q    <= own_dma_d;
      boot_hit_q   <= boot_hit_d;
      cfg_q        <= cfg_d;
      fair_q       <= fair_d;
      bootmode_q   <= bootmode_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      ram_addr_q   <= ram_addr_d;
      rom_addr_q   <= rom_addr_d;
      tube_addr_q  <= tube_addr_d;
      tube_wdata_q <= tube_wdata_d;
    end
  end

  assign cpu_ready = (state_q == ST_DONE) && !own_dma_q;
  assign dma_ack   = (state_q == ST_DONE) && own_dma_q;
  assign cpu_q     = cpu_rdata_q;
  assign dma_q     = dma_rdata_q;
  assign bootmode  = bootmode_q;

  // Strobes decode straight from the state flops so an async reset releases them at once.
  assign ram_cs_b     = ~(state_q == ST_RAM_ACC);
  assign ram_oe_b     = ~((state_q == ST_RAM_ACC) && !wr_q);
  assign ram_we_b     = ~((state_q == ST_RAM_ACC) && wr_q && (cnt_q != '0));
  assign ram_wdata_oe = (state_q == ST_RAM_ACC) && wr_q;
  assign ram_be_b     = (state_q == ST_RAM_ACC) ? ~be_q : '1;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = wdata_q;

  // The ROM is synchronous, so its address is presented in the grant cycle
  // to have data ready by the first ROM_ACC cycle.
  assign rom_addr = (grant_cpu && cpu_region == RGN_ROM) ? cpu_a[14:2] : rom_addr_q;

  assign tube_cs_b  = ~(state_q == ST_TUBE_ACC);
  assign tube_rnw   = ~((state_q == ST_TUBE_ACC) && wr_q);
  assign tube_addr  = tube_addr_q;
  assign tube_wdata = tube_wdata_q;

endmodule

// File: tb/tb_copro_mem_arbiter.sv
// Directed scoreboard bench for copro_mem_arbiter with SRAM and sync-ROM models.
module tb_copro_mem_arbiter;

  localparam int unsigned RAM_W  = 2;
  localparam int unsigned ROM_W  = 1;
  localparam int unsigned TUBE_W = 1;

`ifdef CONFIG_REG_EN
  localparam logic [31:0] CFG_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] CFG_EXP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cpu_rd, cpu_wr;
  logic [23:0] cpu_a;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_di, cpu_q;
  logic        cpu_ready;
  logic        dma_req, dma_wr;
  logic [18:0] dma_a;
  logic [31:0] dma_di, dma_q;
  logic        dma_ack;
  logic        ram_cs_b, ram_oe_b, ram_we_b;
  logic [3:0]  ram_be_b;
  logic [18:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_wdata_oe;
  logic [12:0] rom_addr;
  logic [31:0] rom_data;
  logic        tube_cs_b, tube_rnw;
  logic [2:0]  tube_addr;
  logic [7:0]  tube_wdata, tube_rdata;
  logic [7:0]  cfg_sw;
  logic        bootmode;

  always #5 clk = ~clk;

  copro_mem_arbiter #(
    .RAM_WAIT  (RAM_W),
    .ROM_WAIT  (ROM_W),
    .TUBE_WAIT (TUBE_W)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_rd       (cpu_rd),
    .cpu_wr       (cpu_wr),
    .cpu_a        (cpu_a),
    .cpu_be       (cpu_be),
    .cpu_di       (cpu_di),
    .cpu_q        (cpu_q),
    .cpu_ready    (cpu_ready),
    .dma_req      (dma_req),
    .dma_wr       (dma_wr),
    .dma_a        (dma_a),
    .dma_di       (dma_di),
    .dma_q        (dma_q),
    .dma_ack      (dma_ack),
    .ram_cs_b     (ram_cs_b),
    .ram_oe_b     (ram_oe_b),
    .ram_we_b     (ram_we_b),
    .ram_be_b     (ram_be_b),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_wdata_oe (ram_wdata_oe),
    .ram_rdata    (ram_rdata),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .tube_cs_b    (tube_cs_b),
    .tube_addr    (tube_addr),
    .tube_rnw     (tube_rnw),
    .tube_wdata   (tube_wdata),
    .tube_rdata   (tube_rdata),
    .cfg_sw       (cfg_sw),
    .bootmode     (bootmode)
  );

  // SRAM model: unwritten words read as {C0, word address}.
  bit   [31:0] mem [0:63];
  bit          vld [0:63];
  logic [31:0] ram_cur, ram_merged;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                        input logic [3:0] be_b);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (!be_b[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign ram_cur    = vld[ram_addr[5:0]] ? mem[ram_addr[5:0]] : {8'hC0, 5'b0, ram_addr};
  assign ram_rdata  = ram_cur;
  assign ram_merged = merge(ram_cur, ram_wdata, ram_be_b);

  always @(posedge clk) begin
    if (!ram_cs_b && !ram_we_b) begin
      mem[ram_addr[5:0]] <= ram_merged;
      vld[ram_addr[5:0]] <= 1'b1;
    end
  end

  // Synchronous ROM model: word content is A5A5_0000 | word address.
  always @(posedge clk) rom_data <= 32'hA5A5_0000 | {19'b0, rom_addr};

  typedef struct {
    bit          is_dma;
    bit          chk;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [12:0] obs_rom_addr;
  logic [18:0] obs_ram_addr;
  logic [3:0]  obs_ram_be_b;
  logic [2:0]  obs_tube_addr;
  logic [7:0]  obs_tube_wdata;
  logic        obs_tube_rnw;
  int          n_cs, n_oe, n_we, n_wdoe, n_tube_cs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_dma, input bit chk, input logic [31:0] data,
                          input string tag);
    exp_t e;
    e.is_dma = is_dma;
    e.chk    = chk;
    e.data   = data;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic compare_completion();
    exp_t e;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, " who"}, {30'b0, dma_ack, cpu_ready}, e.is_dma ? 32'd2 : 32'd1);
      if (e.chk) check({e.tag, " data"}, e.is_dma ? dma_q : cpu_q, e.data);
    end
  endtask

  // Waits for the completion of the request just driven, recording bus activity.
  task automatic run_access(input string tag, input int exp_lat);
    int lat;
    bit done;
    lat = 1;
    done = 1'b0;
    n_cs = 0; n_oe = 0; n_we = 0; n_wdoe = 0; n_tube_cs = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) begin
        obs_rom_addr   = rom_addr;
        obs_ram_addr   = ram_addr;
        obs_ram_be_b   = ram_be_b;
        obs_tube_addr  = tube_addr;
        obs_tube_wdata = tube_wdata;
        obs_tube_rnw   = tube_rnw;
      end
      if (!ram_cs_b)  n_cs++;
      if (!ram_oe_b)  n_oe++;
      if (!ram_we_b)  n_we++;
      if (ram_wdata_oe) n_wdoe++;
      if (!tube_cs_b) n_tube_cs++;
      if (cpu_ready || dma_ack) begin
        done = 1'b1;
        compare_completion();
        cpu_rd  = 1'b0;
        cpu_wr  = 1'b0;
        dma_req = 1'b0;
      end
    end
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    dma_req = 1'b0;
    check({tag, " completed"}, 32'(done), 32'd1);
    if (done) check({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic cpu_op(input string tag, input bit wr, input logic [23:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        input logic [31:0] exp, input int exp_lat);
    @(negedge clk);
    push_exp(1'b0, !wr, exp, tag);
    cpu_rd = !wr;
    cpu_wr = wr;
    cpu_a  = a;
    cpu_be = be;
    cpu_di = d;
    run_access(tag, exp_lat);
  endtask

  task automatic dma_op(input string tag, input bit wr, input logic [18:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_lat);
    @(negedge clk);
    push_exp(1'b1, !wr, exp, tag);
    dma_req = 1'b1;
    dma_wr  = wr;
    dma_a   = a;
    dma_di  = d;
    run_access(tag, exp_lat);
  endtask

  initial begin
    int n;
    int acks;
    int rdy;
    rst_b = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_be = '0; cpu_di = '0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_a = '0; dma_di = '0;
    tube_rdata = 8'h00;
    cfg_sw = 8'h03;

    repeat (2) @(negedge clk);
    check("rst handshake", {30'b0, cpu_ready, dma_ack}, 32'd0);
    check("rst cpu_q", cpu_q, 32'd0);
    check("rst dma_q", dma_q, 32'd0);
    check("rst ram strobes", {26'b0, ram_cs_b, ram_oe_b, ram_we_b, ram_wdata_oe, tube_cs_b, tube_rnw},
          32'b111011);
    check("rst ram_be_b", ram_be_b, 32'hF);
    check("rst bootmode", bootmode, 32'd1);
    check("rst rom_addr", rom_addr, 32'd0);
    check("rst ram_addr", ram_addr, 32'd0);
    rst_b = 1'b1;

    // Boot mode: writes are dropped, reads come from ROM.
    cpu_op("boot write", 1'b1, 24'h000000, 4'hF, 32'hFFFF_FFFF, '0, 3);
    check("boot write no ram", n_cs, 0);
    cpu_op("boot read 0", 1'b0, 24'h000000, 4'hF, '0, 32'hA5A5_0000, 1 + ROM_W + 1);
    check("boot read rom_addr", obs_rom_addr, 32'd0);
    @(negedge clk);
    check("bootmode held", bootmode, 32'd1);
    cpu_op("boot read F00004", 1'b0, 24'hF00004, 4'hF, '0, 32'hA5A5_0001, 1 + ROM_W + 1);
    check("F00004 rom_addr", obs_rom_addr, 32'd1);
    @(negedge clk);
    check("bootmode cleared", bootmode, 32'd0);

    // RAM write with partial byte enables, then read back.
    cpu_op("ram write", 1'b1, 24'h000010, 4'h3, 32'h1234_5678, '0, 1 + RAM_W + 1);
    check("ram write addr", obs_ram_addr, 32'd4);
    check("ram write be_b", obs_ram_be_b, 32'hC);
    check("ram write we cycles", n_we, RAM_W - 1);
    check("ram write oe pad cycles", n_wdoe, RAM_W);
    cpu_op("ram read", 1'b0, 24'h000010, 4'hF, '0, 32'hC000_5678, 1 + RAM_W + 1);
    check("ram read oe cycles", n_oe, RAM_W);

    dma_op("dma write", 1'b1, 19'd9, 32'hDEAD_BEEF, '0, 1 + RAM_W + 1);
    check("dma write be_b", obs_ram_be_b, 32'h0);
    check("dma write addr", obs_ram_addr, 32'd9);
    dma_op("dma read", 1'b0, 19'd9, '0, 32'hDEAD_BEEF, 1 + RAM_W + 1);

    // Both requesters held: grants must alternate CPU, DMA, CPU, DMA.
    @(negedge clk);
    push_exp(1'b0, 1'b1, 32'hC000_5678, "alt cpu0");
    push_exp(1'b1, 1'b1, 32'hDEAD_BEEF, "alt dma0");
    push_exp(1'b0, 1'b1, 32'hC000_5678, "alt cpu1");
    push_exp(1'b1, 1'b1, 32'hDEAD_BEEF, "alt dma1");
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_a = 24'h000010; cpu_be = 4'hF;
    dma_req = 1'b1; dma_wr = 1'b0; dma_a = 19'd9;
    n = 0;
    acks = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (cpu_ready || dma_ack) begin
        if (dma_ack) acks++;
        compare_completion();
        n++;
        if (n == 4) begin
          cpu_rd  = 1'b0;
          dma_req = 1'b0;
        end
      end
    end
    cpu_rd  = 1'b0;
    dma_req = 1'b0;
    check("alt completions", n, 4);
    check("alt dma acks", acks, 2);

    // Tube: upper-halfword lane select and read-data replication.
    cpu_op("tube write", 1'b1, 24'hFFFFF2, 4'hF, 32'h12AB_0034, '0, 1 + TUBE_W + 1);
    check("tube addr", obs_tube_addr, 32'd1);
    check("tube wdata", obs_tube_wdata, 32'hAB);
    check("tube rnw", obs_tube_rnw, 32'd0);
    check("tube cs cycles", n_tube_cs, TUBE_W);
    tube_rdata = 8'h5A;
    cpu_op("tube read", 1'b0, 24'hFFFFF0, 4'hF, '0, 32'h5A5A_5A5A, 1 + TUBE_W + 1);
    check("tube read rnw", obs_tube_rnw, 32'd1);

    cpu_op("unmapped read", 1'b0, 24'h400000, 4'hF, '0, 32'h0, 3);
    check("unmapped no ram", n_cs, 0);
    cpu_op("cfg read", 1'b0, 24'hF90000, 4'hF, '0, CFG_EXP, 3);

    // Async reset in the middle of a RAM write.
    @(negedge clk);
    cpu_wr = 1'b1; cpu_a = 24'h000040; cpu_be = 4'hF; cpu_di = 32'h55AA_55AA;
    @(negedge clk);
    check("midwrite pads driven", ram_wdata_oe, 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("abort strobes", {28'b0, ram_cs_b, ram_oe_b, ram_we_b, ram_wdata_oe}, 32'b1110);
    check("abort be_b", ram_be_b, 32'hF);
    cpu_wr = 1'b0;
    rdy = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ready) rdy++;
    end
    check("abort no ready", rdy, 0);
    check("abort bootmode", bootmode, 32'd1);
    rst_b = 1'b1;

    cpu_op("post-reset boot read", 1'b0, 24'h000008, 4'hF, '0, 32'hA5A5_0002, 1 + ROM_W + 1);
    check("post-reset rom_addr", obs_rom_addr, 32'd2);
    check("scoreboard drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
